// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the two-input basic-gate unit: sweeps a/b through 00..11,
// waits a settle time per vector, and checks the seven gate outputs against a truth table.
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [6:0] gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic [6:0] first_fail_mask
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [1:0]    vec, vec_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    err_count_next;
    logic          pass_next;
    logic [1:0]    first_fail_vec_next;
    logic [6:0]    first_fail_mask_next;
    logic [6:0]    expected;
    logic [6:0]    diff;

    // Expected {and,or,nand,nor,xor,xnor,not} for the vector currently driven.
    always_comb begin
        unique case (vec)
            2'b00:   expected = 7'b0011011;
            2'b01:   expected = 7'b0110101;
            2'b10:   expected = 7'b0110100;
            default: expected = 7'b1100010;
        endcase
    end

    assign diff = gate_out ^ expected;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_next           = state;
        vec_next             = vec;
        cnt_next             = cnt;
        err_count_next       = err_count;
        pass_next            = pass;
        first_fail_vec_next  = first_fail_vec;
        first_fail_mask_next = first_fail_mask;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next           = SETTLE;
                    vec_next             = 2'b00;
                    cnt_next             = '0;
                    err_count_next       = 3'd0;
                    pass_next            = 1'b0;
                    first_fail_vec_next  = 2'b00;
                    first_fail_mask_next = 7'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                    vec_next   = 2'b00;
                    pass_next  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = IDLE;
                    vec_next   = 2'b00;
                    pass_next  = 1'b0;
                end else begin
                    if (diff != 7'd0) begin
                        err_count_next = err_count + 3'd1;
                        if (err_count == 3'd0) begin
                            first_fail_vec_next  = vec;
                            first_fail_mask_next = diff;
                        end
                    end
                    if (vec == 2'b11) begin
                        state_next = DONE;
                        // Verdict uses the count including this final check.
                        pass_next  = (err_count_next == 3'd0);
                    end else begin
                        state_next = SETTLE;
                        vec_next   = vec + 2'b01;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                vec_next   = 2'b00;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
    // non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= 2'b00;
            cnt             <= '0;
            err_count       <= 3'd0;
            pass            <= 1'b0;
            first_fail_vec  <= 2'b00;
            first_fail_mask <= 7'd0;
        end else begin
            state           <= state_next;
            vec             <= vec_next;
            cnt             <= cnt_next;
            err_count       <= err_count_next;
            pass            <= pass_next;
            first_fail_vec  <= first_fail_vec_next;
            first_fail_mask <= first_fail_mask_next;
        end
    end

    assign a    = vec[1];
    assign b    = vec[0];
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: a default build (settle 2) and a settle-1 build
// share stimulus, each fed by a behavioural gate unit with selectable faults.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   fault = 0;

    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [1:0] fv0;
    logic [6:0] fm0, go0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] fv1;
    logic [6:0] fm1, go1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Behavioural gate unit: 0 = healthy, 1 = xor stuck-at-0, 2 = not output inverted.
    function automatic logic [6:0] gate_model(input logic ia, input logic ib, input int f);
        logic [6:0] g;
        g = {ia & ib, ia | ib, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib), ~ia};
        if (f == 1) g[2] = 1'b0;
        if (f == 2) g[0] = ~g[0];
        return g;
    endfunction

    assign go0 = gate_model(a0, b0, fault);
    assign go1 = gate_model(a1, b1, fault);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(go0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(fv0), .first_fail_mask(fm0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(go1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(fv1), .first_fail_mask(fm1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ab0"}, {a0, b0}, 0);
        check({tag, "_busy0"}, busy0, 0);
        check({tag, "_done0"}, done0, 0);
        check({tag, "_pass0"}, pass0, 0);
        check({tag, "_err0"}, err0, 0);
        check({tag, "_fv0"}, fv0, 0);
        check({tag, "_fm0"}, fm0, 0);
        check({tag, "_busy1"}, busy1, 0);
        check({tag, "_err1"}, err1, 0);
    endtask

    // Cycle k is the cycle following edge T+k; start is sampled at edge T.
    task automatic sweep(input string tag, input int f, input bit repulse,
                         input logic [2:0] e_err, input logic [1:0] e_vec,
                         input logic [6:0] e_mask, input bit e_pass);
        fault = f;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= 12) check($sformatf("%s_ab0_k%0d", tag, k), {a0, b0}, (k - 1) / 3);
            check($sformatf("%s_done0_k%0d", tag, k), done0, (k == 13));
            check($sformatf("%s_busy0_k%0d", tag, k), busy0, (k <= 12));
            if (!repulse || k <= 12) begin
                if (k <= 8) check($sformatf("%s_ab1_k%0d", tag, k), {a1, b1}, (k - 1) / 2);
                check($sformatf("%s_done1_k%0d", tag, k), done1, (k == 9));
                check($sformatf("%s_busy1_k%0d", tag, k), busy1, (k <= 8));
            end
            if (repulse && (k == 5 || k == 13)) start = 1'b1;
        end
        check({tag, "_err0"}, err0, e_err);
        check({tag, "_fv0"}, fv0, e_vec);
        check({tag, "_fm0"}, fm0, e_mask);
        check({tag, "_pass0"}, pass0, e_pass);
        if (!repulse) begin
            check({tag, "_err1"}, err1, e_err);
            check({tag, "_fv1"}, fv1, e_vec);
            check({tag, "_fm1"}, fm1, e_mask);
            check({tag, "_pass1"}, pass1, e_pass);
        end
        repeat (repulse ? 14 : 3) @(negedge clk);
        fault = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        sweep("clean", 0, 1'b0, 3'd0, 2'b00, 7'b0000000, 1'b1);
        sweep("xor_sa0", 1, 1'b0, 3'd2, 2'b01, 7'b0000100, 1'b0);
        sweep("not_inv", 2, 1'b0, 3'd4, 2'b00, 7'b0000001, 1'b0);

        // Abort during the SETTLE of vector 10 (cycles 7-8 for the default build).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_pre_ab0", {a0, b0}, 2'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ab0", {a0, b0}, 0);
        check("abort_busy0", busy0, 0);
        check("abort_pass0", pass0, 0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("abort_nodone0_%0d", i), done0, 0);
            @(negedge clk);
        end
        sweep("post_abort", 0, 1'b0, 3'd0, 2'b00, 7'b0000000, 1'b1);

        sweep("repulse", 0, 1'b1, 3'd0, 2'b00, 7'b0000000, 1'b1);

        // Mid-sweep reset after a failing vector has been counted.
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_err_before", err0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("midrst");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone0_%0d", i), done0, 0);
        end
        fault = 0;

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy0", busy0, 0);
        check("sa_busy1", busy1, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("sa_nodone0_%0d", i), done0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-test sequencer for the two-input basic-gate unit (and/or/nand/nor/xor/xnor/not). On a start pulse it drives the unit's a/b inputs through all four vectors (00, 01, 10, 11), waits a programmable settle time per vector, and samples the seven gate outputs. Each sample is checked against a built-in truth table, and the block reports pass/fail, error count and the first failing vector/bit mask. It sits beside the gate unit as its stimulus/check controller.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request to begin a sweep
abort  input  1  cancel a sweep in progress
gate_out  input  7  gate unit outputs {and,or,nand,nor,xor,xnor,not}, bit6=and ... bit0=not
a  output  1  gate unit input a (registered)
b  output  1  gate unit input b (registered)
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, sweep completed
pass  output  1  1 = last completed sweep had zero errors
err_count  output  3  mismatching vectors in last sweep, 0..4
first_fail_vec  output  2  {a,b} of first mismatching vector
first_fail_mask  output  7  gate_out XOR expected at first mismatch

Behaviour:
- Clocking: one clock; reset is synchronous and active-low. All state changes on rising clk edge.
- Reset (rst_n=0 at an edge): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0. Applies from any state, including mid-sweep.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: busy=0. start=1 && abort=0 -> SETTLE. On that edge: vec=0 ({a,b}=00), settle counter=0, err_count=0, pass=0, first_fail_vec=0, first_fail_mask=0.
- SETTLE: busy=1. Held for exactly SETTLE_CYCLES cycles, then -> CHECK.
- CHECK: busy=1. gate_out is sampled in this cycle and compared to the expected value:
  - 00 -> 7'b0011011
  - 01 -> 7'b0110101
  - 10 -> 7'b0110100
  - 11 -> 7'b1100010
  - not output = ~a.
  - On mismatch: err_count += 1. If this is the first mismatch of the sweep, latch first_fail_vec=vec and first_fail_mask=gate_out^expected.
  - If vec<3: -> SETTLE with vec+1 driven onto a/b at the same edge and the counter cleared.
  - If vec==3: -> DONE.
- DONE: busy=0, done=1 for exactly one cycle. pass = (final err_count==0), taking the CHECK of vector 3 into account. Then -> IDLE.
- Results (pass, err_count, first_fail_*) hold until the next accepted start or reset.
- Timing: start sampled at edge T. a/b valid from T+1. Each vector occupies SETTLE_CYCLES+1 cycles. done is high in cycle T+4*(SETTLE_CYCLES+1)+1, i.e. T+13 for default 2.
- start while busy or in DONE: ignored (no restart, no queueing).
- abort=1 in SETTLE or CHECK: -> IDLE at next edge.
  - a=b=0, busy=0, no done pulse, pass=0.
  - err_count and first_fail_* keep their partial values and are not meaningful.
- abort in the same cycle as start in IDLE: abort wins, stay IDLE.
- abort in DONE: ignored; the done pulse completes.
- err_count saturates naturally at 4 (3 bits, max 4 vectors); no wrap.
- Settle counter width: clog2(SETTLE_CYCLES+1).

Test Plan:
1. Reset then start at T with a correct gate unit -> a/b sequence 00, 01, 10, 11, each held 3 cycles; done=1 at T+13 only; pass=1, err_count=0, busy low from T+13.
2. Model xor stuck-at-0 -> mismatches on 01 and 10; err_count=2, first_fail_vec=2'b01, first_fail_mask=7'b0000100, pass=0.
3. Invert not output (gate_out[0]) -> all 4 vectors fail; err_count=4, first_fail_vec=00, first_fail_mask=7'b0000001.
4. abort asserted during vector 10 SETTLE -> IDLE next edge, a=b=0, busy=0, no done pulse, pass=0. A fresh start then runs a full clean sweep with pass=1.
5. start re-pulsed at T+5 and in the DONE cycle -> ignored, single done at T+13. rst_n=0 at T+6 -> all outputs at reset values the next cycle, no done.
6. SETTLE_CYCLES=1 build -> each vector held 2 cycles, done at T+9. start && abort together in IDLE -> no sweep.
